inv_kin_harness: RTL

Synthesisable stimulus-and-capture harness for the `inv_kin` inverse-kinematics kernel. It generates NUM_VECTORS (x, y) Q-format operand pairs, either pseudo-random or as a deterministic sweep, and drives them into the kernel. After a programmable settle interval it samples (theta1, theta2) and pushes {x, y, theta1, theta2} records into an output FIFO with valid/ready back-pressure. It replaces fixed-delay simulation stimulus so the same vector runs can execute on FPGA or in emulation.

---
 rtl/inv_kin_harness_if.sv | 27 ++
 rtl/inv_kin_harness.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/inv_kin_harness_if.sv
// Output record stream of the inverse-kinematics harness.
// The master (harness) presents the head record of its FIFO with out_valid.
// The slave (consumer) accepts that record by raising out_ready.
//   out_valid              : a head record is present
//   out_ready              : consumer accepts the head record this cycle
//   out_x/out_y            : operands that were applied to the kernel
//   out_theta1/out_theta2  : kernel results sampled for those operands
interface inv_kin_harness_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] out_x;
  logic [BIT_WIDTH-1:0] out_y;
  logic [BIT_WIDTH-1:0] out_theta1;
  logic [BIT_WIDTH-1:0] out_theta2;

  modport master (
    output out_valid, out_x, out_y, out_theta1, out_theta2,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_x, out_y, out_theta1, out_theta2,
    output out_ready
  );
endinterface

// File: rtl/inv_kin_harness.sv
// Stimulus-and-capture harness for the inv_kin kernel.
// Each run generates NUM_VECTORS operand pairs, either from a Galois LFSR or
// from a sweep of x. Each pair is held on dut_x/dut_y for SETTLE_CYCLES, then
// the results are captured into a first-word-fall-through FIFO as
// {x, y, theta1, theta2} records.
// Ports:
//   clock, rst             : rising-edge clock, async active-high reset
//   start, mode            : begin a run (0 = LFSR random, 1 = sweep)
//   busy, done             : run in progress / run finished
//   vector_count           : records captured in the current run
//   dut_x, dut_y           : registered operands to the kernel
//   dut_theta1, dut_theta2 : kernel results
//   rec                    : output record stream (master side)
module inv_kin_harness #(
  parameter int          BIT_WIDTH     = 32,
  parameter int          FRACTIONS     = 15,
  parameter int          NUM_VECTORS   = 1000,
  parameter int          SETTLE_CYCLES = 500,
  parameter logic [31:0] SEED          = 32'd7,
  parameter logic [31:0] SWEEP_Y       = 32'h0000_8000,
  parameter int          FIFO_DEPTH    = 16
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          vector_count,
  output logic [BIT_WIDTH-1:0] dut_x,
  output logic [BIT_WIDTH-1:0] dut_y,
  input  logic [BIT_WIDTH-1:0] dut_theta1,
  input  logic [BIT_WIDTH-1:0] dut_theta2,
  inv_kin_harness_if.master    rec
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CAPTURE, DONE} state_t;

  typedef struct packed {
    logic [BIT_WIDTH-1:0] x;
    logic [BIT_WIDTH-1:0] y;
    logic [BIT_WIDTH-1:0] theta1;
    logic [BIT_WIDTH-1:0] theta2;
  } rec_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  state_t        state, state_nx;
  logic [31:0]   lfsr, sweep_idx, settle_cnt;
  logic          mode_q;
  logic [31:0]   s1, s2, sweep_sh;
  logic          push, pop, last;

  rec_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcount;
  rec_t          head;

  assign s1       = lfsr_step(lfsr);
  assign s2       = lfsr_step(s1);
  assign sweep_sh = sweep_idx << FRACTIONS;

  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign pop  = rec.out_valid && rec.out_ready;
  assign push = (state == CAPTURE) && ((fcount != (AW+1)'(FIFO_DEPTH)) || pop);
  assign last = (vector_count + 32'd1) == 32'(NUM_VECTORS);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    begin busy = 1'b1; state_nx = SETTLE; end
      SETTLE:  begin busy = 1'b1; if (settle_cnt == 32'd0) state_nx = CAPTURE; end
      CAPTURE: begin
        busy = 1'b1;
        if (push) state_nx = last ? DONE : LOAD;
      end
      DONE:    begin done = 1'b1; if (start) state_nx = LOAD; end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      lfsr         <= SEED_EFF;
      sweep_idx    <= '0;
      mode_q       <= 1'b0;
      vector_count <= '0;
      settle_cnt   <= '0;
      dut_x        <= '0;
      dut_y        <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          vector_count <= '0;
          sweep_idx    <= '0;
          mode_q       <= mode;
        end
        LOAD: begin
          if (mode_q) begin
            dut_x <= sweep_sh[BIT_WIDTH-1:0];
            dut_y <= SWEEP_Y[BIT_WIDTH-1:0];
          end else begin
            // LFSR advances two steps per vector: one for x, one for y.
            lfsr  <= s2;
            dut_x <= s1[BIT_WIDTH-1:0];
            dut_y <= s2[BIT_WIDTH-1:0];
          end
          settle_cnt <= 32'(SETTLE_CYCLES - 1);
        end
        SETTLE: if (settle_cnt != 32'd0) settle_cnt <= settle_cnt - 32'd1;
        CAPTURE: if (push) begin
          vector_count <= vector_count + 32'd1;
          sweep_idx    <= sweep_idx + 32'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{x: dut_x, y: dut_y, theta1: dut_theta1, theta2: dut_theta2};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fcount <= fcount + 1'b1;
        2'b01:   fcount <= fcount - 1'b1;
        default: fcount <= fcount;
      endcase
    end
  end

  // Head is forced to zero while empty so stale entries never show.
  assign head           = mem[rd_ptr];
  assign rec.out_valid  = (fcount != '0);
  assign rec.out_x      = rec.out_valid ? head.x      : '0;
  assign rec.out_y      = rec.out_valid ? head.y      : '0;
  assign rec.out_theta1 = rec.out_valid ? head.theta1 : '0;
  assign rec.out_theta2 = rec.out_valid ? head.theta2 : '0;
endmodule
